// File: rtl/aes_gcm_issue_scheduler.sv
// ---------------------------------------------------------------------------
// aes_gcm_issue_scheduler
//
// Front-end sequencer for the AES-GCM pipeline. Accepts one GCM instance at
// a time and turns it into a stream of pipeline beats, in this order:
//   HJ0 beat -> AAD beats -> PT beats (with counter blocks) -> LEN beat.
// This block is the only writer of the first pipeline stage inputs.
//
// Parameters
//   CNT_W            width of the block counts (1..57 so bit lengths fit 64b)
//
// Ports
//   clk, rst         pipeline clock, asynchronous active-high reset
//   i_start          instance request valid
//   o_start_ready    high only in IDLE; accept = i_start && o_start_ready
//   i_j0             pre-counter block J0, sampled on accept
//   i_aad_blocks     number of 128-bit AAD blocks, sampled on accept
//   i_pt_blocks      number of 128-bit plaintext blocks, sampled on accept
//   i_aad/_valid     AAD block source, o_aad_ready high only in AAD state
//   i_pt/_valid      plaintext block source, o_pt_ready high only in PT state
//   o_valid          a pipeline beat is present this cycle
//   o_phase          0 bubble, 1 HJ0, 2 AAD, 3 PT, 4 LEN
//   o_h              hash-subkey seed (all-zero)
//   o_encrypted_j0   latched J0, held for the whole instance
//   o_encrypted_cb   counter block on PT beats, 0 otherwise
//   o_aad            AAD data on AAD beats, length block on LEN beat
//   o_plain_text     plaintext on PT beats
//   o_instance_size  {aad_bits, pt_bits}, held for the whole instance
//   o_busy           state is not IDLE
//   o_done           one-cycle pulse coincident with the LEN beat
// ---------------------------------------------------------------------------
module aes_gcm_issue_scheduler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  output logic             o_start_ready,
  input  logic [127:0]     i_j0,
  input  logic [CNT_W-1:0] i_aad_blocks,
  input  logic [CNT_W-1:0] i_pt_blocks,
  input  logic [127:0]     i_aad,
  input  logic             i_aad_valid,
  output logic             o_aad_ready,
  input  logic [127:0]     i_pt,
  input  logic             i_pt_valid,
  output logic             o_pt_ready,
  output logic             o_valid,
  output logic [2:0]       o_phase,
  output logic [127:0]     o_h,
  output logic [127:0]     o_encrypted_j0,
  output logic [127:0]     o_encrypted_cb,
  output logic [127:0]     o_aad,
  output logic [127:0]     o_plain_text,
  output logic [127:0]     o_instance_size,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HJ0  = 3'd1,
    S_AAD  = 3'd2,
    S_PT   = 3'd3,
    S_LEN  = 3'd4
  } state_t;

  localparam logic [2:0] PH_BUBBLE = 3'd0;
  localparam logic [2:0] PH_HJ0    = 3'd1;
  localparam logic [2:0] PH_AAD    = 3'd2;
  localparam logic [2:0] PH_PT     = 3'd3;
  localparam logic [2:0] PH_LEN    = 3'd4;

  state_t             r_state;
  logic [CNT_W-1:0]   r_aad_left;
  logic [CNT_W-1:0]   r_pt_left;
  logic [127:0]       r_cb;

  logic [63:0]        w_aad_bits;
  logic [63:0]        w_pt_bits;

  // GCM inc32: only the rightmost 32 bits count, wrapping without carrying
  // into the fixed 96-bit prefix.
  function automatic logic [127:0] inc32(input logic [127:0] b);
    return {b[127:32], b[31:0] + 32'd1};
  endfunction

  // Bit lengths are block counts times 128, zero-extended to 64 bits.
  assign w_aad_bits = 64'(i_aad_blocks) << 7;
  assign w_pt_bits  = 64'(i_pt_blocks) << 7;

  // Handshake readies and busy come straight from the state register so no
  // input can ripple combinationally to an output.
  assign o_start_ready = (r_state == S_IDLE);
  assign o_aad_ready   = (r_state == S_AAD);
  assign o_pt_ready    = (r_state == S_PT);
  assign o_busy        = (r_state != S_IDLE);

  // Single sequencer: every beat output is registered here. Per-beat fields
  // default to a bubble each cycle; J0 and instance size are only written on
  // accept so they stay held across bubbles for the whole instance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_aad_left      <= '0;
      r_pt_left       <= '0;
      r_cb            <= '0;
      o_valid         <= 1'b0;
      o_phase         <= PH_BUBBLE;
      o_h             <= '0;
      o_encrypted_j0  <= '0;
      o_encrypted_cb  <= '0;
      o_aad           <= '0;
      o_plain_text    <= '0;
      o_instance_size <= '0;
      o_done          <= 1'b0;
    end else begin
      o_valid        <= 1'b0;
      o_phase        <= PH_BUBBLE;
      o_h            <= '0;
      o_encrypted_cb <= '0;
      o_aad          <= '0;
      o_plain_text   <= '0;
      o_done         <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            o_encrypted_j0  <= i_j0;
            o_instance_size <= {w_aad_bits, w_pt_bits};
            r_cb            <= inc32(i_j0);
            r_aad_left      <= i_aad_blocks;
            r_pt_left       <= i_pt_blocks;
            r_state         <= S_HJ0;
          end
        end

        S_HJ0: begin
          o_valid <= 1'b1;
          o_phase <= PH_HJ0;
          if (r_aad_left != '0)
            r_state <= S_AAD;
          else if (r_pt_left != '0)
            r_state <= S_PT;
          else
            r_state <= S_LEN;
        end

        S_AAD: begin
          if (i_aad_valid) begin
            o_valid    <= 1'b1;
            o_phase    <= PH_AAD;
            o_aad      <= i_aad;
            r_aad_left <= r_aad_left - CNT_W'(1);
            if (r_aad_left == CNT_W'(1))
              r_state <= (r_pt_left != '0) ? S_PT : S_LEN;
          end
        end

        S_PT: begin
          if (i_pt_valid) begin
            o_valid        <= 1'b1;
            o_phase        <= PH_PT;
            o_plain_text   <= i_pt;
            o_encrypted_cb <= r_cb;
            r_cb           <= inc32(r_cb);
            r_pt_left      <= r_pt_left - CNT_W'(1);
            if (r_pt_left == CNT_W'(1))
              r_state <= S_LEN;
          end
        end

        S_LEN: begin
          o_valid <= 1'b1;
          o_phase <= PH_LEN;
          o_aad   <= o_instance_size;
          o_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_gcm_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_gcm_issue_scheduler
//
// Directed bench for aes_gcm_issue_scheduler. Inputs change #1 after a rising
// edge and outputs are sampled at that same point, so each tick() shows the
// registered result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_aes_gcm_issue_scheduler;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          o_start_ready;
  logic [127:0]  i_j0;
  logic [31:0]   i_aad_blocks;
  logic [31:0]   i_pt_blocks;
  logic [127:0]  i_aad;
  logic          i_aad_valid;
  logic          o_aad_ready;
  logic [127:0]  i_pt;
  logic          i_pt_valid;
  logic          o_pt_ready;
  logic          o_valid;
  logic [2:0]    o_phase;
  logic [127:0]  o_h;
  logic [127:0]  o_encrypted_j0;
  logic [127:0]  o_encrypted_cb;
  logic [127:0]  o_aad;
  logic [127:0]  o_plain_text;
  logic [127:0]  o_instance_size;
  logic          o_busy;
  logic          o_done;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  aes_gcm_issue_scheduler #(.CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .o_start_ready   (o_start_ready),
    .i_j0            (i_j0),
    .i_aad_blocks    (i_aad_blocks),
    .i_pt_blocks     (i_pt_blocks),
    .i_aad           (i_aad),
    .i_aad_valid     (i_aad_valid),
    .o_aad_ready     (o_aad_ready),
    .i_pt            (i_pt),
    .i_pt_valid      (i_pt_valid),
    .o_pt_ready      (o_pt_ready),
    .o_valid         (o_valid),
    .o_phase         (o_phase),
    .o_h             (o_h),
    .o_encrypted_j0  (o_encrypted_j0),
    .o_encrypted_cb  (o_encrypted_cb),
    .o_aad           (o_aad),
    .o_plain_text    (o_plain_text),
    .o_instance_size (o_instance_size),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step one rising edge and move to the sample/drive point just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an instance request onto the start interface.
  task automatic applyStimulus(input logic start, input logic [127:0] j0,
                               input logic [31:0] aadN, input logic [31:0] ptN);
    i_start      = start;
    i_j0         = j0;
    i_aad_blocks = aadN;
    i_pt_blocks  = ptN;
  endtask

  // One comparison: counts it, and reports a failure with both values.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Full per-beat view: valid, phase, counter block, aad field, plaintext, done.
  task automatic checkBeat(input string tag, input logic v, input logic [2:0] ph,
                           input logic [127:0] cb, input logic [127:0] ad,
                           input logic [127:0] pt, input logic dn);
    checkOutput({tag, ".valid"}, 128'(o_valid), 128'(v));
    checkOutput({tag, ".phase"}, 128'(o_phase), 128'(ph));
    checkOutput({tag, ".cb"}, o_encrypted_cb, cb);
    checkOutput({tag, ".aad"}, o_aad, ad);
    checkOutput({tag, ".pt"}, o_plain_text, pt);
    checkOutput({tag, ".done"}, 128'(o_done), 128'(dn));
  endtask

  logic [127:0] j0a;
  logic [127:0] j0b;
  logic [127:0] j0c;
  logic [127:0] j0d;
  logic [127:0] j0e;
  logic [127:0] j0f;

  initial begin
    j0a = {96'hCAFEBABE_01234567_89ABCDEF, 32'h0000_0001};
    j0b = {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'hFFFF_FFFE};
    j0c = {96'h1111_2222_3333_4444_5555_6666, 32'h0000_0000};
    j0d = {96'hDEAD_BEEF_0000_1111_2222_3333, 32'h0000_0010};
    j0e = {96'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F, 32'h0000_0020};
    j0f = {96'h7777_8888_9999_AAAA_BBBB_CCCC, 32'h0000_0007};

    rst         = 1'b1;
    i_aad       = '0;
    i_aad_valid = 1'b0;
    i_pt        = '0;
    i_pt_valid  = 1'b0;
    applyStimulus(1'b0, '0, 32'd0, 32'd0);

    // Reset state
    tick();
    tick();
    checkOutput("rst.start_ready", 128'(o_start_ready), 128'(1'b1));
    checkOutput("rst.busy", 128'(o_busy), 128'(1'b0));
    checkOutput("rst.aad_ready", 128'(o_aad_ready), 128'(1'b0));
    checkOutput("rst.pt_ready", 128'(o_pt_ready), 128'(1'b0));
    checkOutput("rst.j0", o_encrypted_j0, 128'h0);
    checkOutput("rst.size", o_instance_size, 128'h0);
    checkBeat("rst", 1'b0, 3'd0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    tick();

    // Basic instance: 1 AAD, 2 PT, inputs valid throughout
    $display("[TB] basic instance");
    applyStimulus(1'b1, j0a, 32'd1, 32'd2);
    i_aad       = 128'hAAAA_0001;
    i_aad_valid = 1'b1;
    i_pt        = 128'hBBBB_0001;
    i_pt_valid  = 1'b1;
    tick();
    i_start = 1'b0;
    checkOutput("basic.accept.busy", 128'(o_busy), 128'(1'b1));
    checkOutput("basic.accept.start_ready", 128'(o_start_ready), 128'(1'b0));
    checkOutput("basic.j0", o_encrypted_j0, j0a);
    checkOutput("basic.size", o_instance_size, {64'd128, 64'd256});
    checkBeat("basic.pre", 1'b0, 3'd0, '0, '0, '0, 1'b0);
    tick();
    checkBeat("basic.hj0", 1'b1, 3'd1, '0, '0, '0, 1'b0);
    checkOutput("basic.h", o_h, 128'h0);
    checkOutput("basic.aad_ready", 128'(o_aad_ready), 128'(1'b1));
    tick();
    checkBeat("basic.aad0", 1'b1, 3'd2, '0, 128'hAAAA_0001, '0, 1'b0);
    checkOutput("basic.pt_ready", 128'(o_pt_ready), 128'(1'b1));
    tick();
    checkBeat("basic.pt0", 1'b1, 3'd3, {j0a[127:32], 32'h2}, '0, 128'hBBBB_0001, 1'b0);
    i_pt = 128'hBBBB_0002;
    tick();
    checkBeat("basic.pt1", 1'b1, 3'd3, {j0a[127:32], 32'h3}, '0, 128'hBBBB_0002, 1'b0);
    tick();
    checkBeat("basic.len", 1'b1, 3'd4, '0, {64'd128, 64'd256}, '0, 1'b1);
    checkOutput("basic.len.start_ready", 128'(o_start_ready), 128'(1'b1));
    tick();
    checkBeat("basic.after", 1'b0, 3'd0, '0, '0, '0, 1'b0);
    checkOutput("basic.after.start_ready", 128'(o_start_ready), 128'(1'b1));
    checkOutput("basic.after.j0held", o_encrypted_j0, j0a);
    i_aad_valid = 1'b0;

    // Counter wrap: low word FFFFFFFE, 3 PT blocks
    $display("[TB] counter wrap");
    applyStimulus(1'b1, j0b, 32'd0, 32'd3);
    i_pt = 128'hC0C0;
    tick();
    i_start = 1'b0;
    tick();
    checkBeat("wrap.hj0", 1'b1, 3'd1, '0, '0, '0, 1'b0);
    checkOutput("wrap.j0", o_encrypted_j0, j0b);
    tick();
    checkBeat("wrap.pt0", 1'b1, 3'd3, {j0b[127:32], 32'hFFFF_FFFF}, '0, 128'hC0C0, 1'b0);
    tick();
    checkBeat("wrap.pt1", 1'b1, 3'd3, {j0b[127:32], 32'h0000_0000}, '0, 128'hC0C0, 1'b0);
    tick();
    checkBeat("wrap.pt2", 1'b1, 3'd3, {j0b[127:32], 32'h0000_0001}, '0, 128'hC0C0, 1'b0);
    tick();
    checkBeat("wrap.len", 1'b1, 3'd4, '0, {64'd0, 64'd384}, '0, 1'b1);
    i_pt_valid = 1'b0;
    tick();

    // Empty instance: HJ0 directly followed by LEN
    $display("[TB] empty instance");
    applyStimulus(1'b1, j0c, 32'd0, 32'd0);
    tick();
    i_start = 1'b0;
    tick();
    checkBeat("empty.hj0", 1'b1, 3'd1, '0, '0, '0, 1'b0);
    tick();
    checkBeat("empty.len", 1'b1, 3'd4, '0, 128'h0, '0, 1'b1);
    checkOutput("empty.size", o_instance_size, 128'h0);
    tick();
    checkOutput("empty.after.start_ready", 128'(o_start_ready), 128'(1'b1));
    checkBeat("empty.after", 1'b0, 3'd0, '0, '0, '0, 1'b0);

    // Throttled source: pt_valid 1,0,0,1 over the PT handshake edges
    $display("[TB] throttled source");
    applyStimulus(1'b1, j0d, 32'd0, 32'd2);
    tick();
    i_start = 1'b0;
    i_pt       = 128'hD00D_0001;
    i_pt_valid = 1'b1;
    tick();
    checkBeat("thr.hj0", 1'b1, 3'd1, '0, '0, '0, 1'b0);
    tick();
    checkBeat("thr.pt0", 1'b1, 3'd3, {j0d[127:32], 32'h11}, '0, 128'hD00D_0001, 1'b0);
    i_pt_valid = 1'b0;
    tick();
    checkBeat("thr.gap0", 1'b0, 3'd0, '0, '0, '0, 1'b0);
    checkOutput("thr.gap0.j0held", o_encrypted_j0, j0d);
    checkOutput("thr.gap0.sizeheld", o_instance_size, {64'd0, 64'd256});
    tick();
    checkBeat("thr.gap1", 1'b0, 3'd0, '0, '0, '0, 1'b0);
    i_pt       = 128'hD00D_0002;
    i_pt_valid = 1'b1;
    tick();
    checkBeat("thr.pt1", 1'b1, 3'd3, {j0d[127:32], 32'h12}, '0, 128'hD00D_0002, 1'b0);
    i_pt_valid = 1'b0;
    tick();
    checkBeat("thr.len", 1'b1, 3'd4, '0, {64'd0, 64'd256}, '0, 1'b1);
    tick();

    // Mid-instance reset after 1 of 4 PT blocks
    $display("[TB] mid-instance reset");
    applyStimulus(1'b1, j0e, 32'd0, 32'd4);
    i_pt       = 128'hE0E0;
    i_pt_valid = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    checkBeat("mrst.pt0", 1'b1, 3'd3, {j0e[127:32], 32'h21}, '0, 128'hE0E0, 1'b0);
    rst = 1'b1;
    #1;
    checkBeat("mrst.async", 1'b0, 3'd0, '0, '0, '0, 1'b0);
    checkOutput("mrst.async.j0", o_encrypted_j0, 128'h0);
    checkOutput("mrst.async.size", o_instance_size, 128'h0);
    checkOutput("mrst.async.busy", 128'(o_busy), 128'(1'b0));
    checkOutput("mrst.async.pt_ready", 128'(o_pt_ready), 128'(1'b0));
    checkOutput("mrst.async.start_ready", 128'(o_start_ready), 128'(1'b1));
    tick();
    rst        = 1'b0;
    i_pt_valid = 1'b0;
    tick();
    checkOutput("mrst.rel.start_ready", 128'(o_start_ready), 128'(1'b1));
    checkBeat("mrst.rel", 1'b0, 3'd0, '0, '0, '0, 1'b0);

    // Fresh instance after the abandoned one: 1 AAD, 1 PT
    applyStimulus(1'b1, j0f, 32'd1, 32'd1);
    i_aad       = 128'hF00D_0001;
    i_aad_valid = 1'b1;
    i_pt        = 128'hF00D_0002;
    i_pt_valid  = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    checkBeat("mrst.new.hj0", 1'b1, 3'd1, '0, '0, '0, 1'b0);
    checkOutput("mrst.new.j0", o_encrypted_j0, j0f);
    tick();
    checkBeat("mrst.new.aad", 1'b1, 3'd2, '0, 128'hF00D_0001, '0, 1'b0);
    tick();
    checkBeat("mrst.new.pt", 1'b1, 3'd3, {j0f[127:32], 32'h8}, '0, 128'hF00D_0002, 1'b0);
    tick();
    checkBeat("mrst.new.len", 1'b1, 3'd4, '0, {64'd128, 64'd128}, '0, 1'b1);
    i_aad_valid = 1'b0;
    i_pt_valid  = 1'b0;
    tick();

    // Ordering with i_start held high: no re-accept until after LEN
    $display("[TB] held start ordering");
    applyStimulus(1'b1, j0a, 32'd2, 32'd0);
    i_aad       = 128'h0A0A_0001;
    i_aad_valid = 1'b1;
    tick();
    tick();
    checkBeat("ord.hj0", 1'b1, 3'd1, '0, '0, '0, 1'b0);
    checkOutput("ord.hj0.busy", 128'(o_busy), 128'(1'b1));
    tick();
    checkBeat("ord.aad0", 1'b1, 3'd2, '0, 128'h0A0A_0001, '0, 1'b0);
    i_aad = 128'h0A0A_0002;
    tick();
    checkBeat("ord.aad1", 1'b1, 3'd2, '0, 128'h0A0A_0002, '0, 1'b0);
    checkOutput("ord.aad1.start_ready", 128'(o_start_ready), 128'(1'b0));
    applyStimulus(1'b1, j0c, 32'd0, 32'd0);
    tick();
    checkBeat("ord.len", 1'b1, 3'd4, '0, {64'd256, 64'd0}, '0, 1'b1);
    checkOutput("ord.len.j0", o_encrypted_j0, j0a);
    tick();
    i_start     = 1'b0;
    i_aad_valid = 1'b0;
    checkBeat("ord.reaccept", 1'b0, 3'd0, '0, '0, '0, 1'b0);
    checkOutput("ord.reaccept.busy", 128'(o_busy), 128'(1'b1));
    checkOutput("ord.reaccept.j0", o_encrypted_j0, j0c);
    tick();
    checkBeat("ord.hj0b", 1'b1, 3'd1, '0, '0, '0, 1'b0);
    tick();
    checkBeat("ord.lenb", 1'b1, 3'd4, '0, 128'h0, '0, 1'b1);
    tick();
    checkOutput("ord.end.busy", 128'(o_busy), 128'(1'b0));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
